// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial addition controller.
//   state_t        : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width in bits
//   clog2()        : width of the bit counter for a given operand width
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_full_adder.sv
// bit_full_adder
// Purely combinational 1-bit full adder built from two half-adder stages
// whose carries are ORed together.
//   a, b  : input  1  operand bits
//   cin   : input  1  carry in
//   s     : output 1  sum bit
//   cout  : output 1  carry out
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  // First half adder combines the operands, second folds in the carry.
  // Both half-adder carries can never be high together, so OR suffices.
  assign ha1_s = a ^ b;
  assign ha1_c = a & b;
  assign s     = ha1_s ^ cin;
  assign ha2_c = ha1_s & cin;
  assign cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder: one full-adder cell is reused across the WIDTH bits of
// the operands, LSB first, one bit per enabled clock.
//   clk    : input  1        clock, rising edge
//   rst_n  : input  1        asynchronous active-low reset
//   ena    : input  1        global enable; low freezes all state
//   start  : input  1        request a new addition (level-sampled)
//   a, b   : input  WIDTH    operands, captured when start is accepted
//   busy   : output 1        high while the addition is running
//   done   : output 1        one-cycle pulse, result valid from this cycle
//   sum    : output WIDTH+1  {carry_out, sum bits}, held until next accept
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;

  bit_full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // A new request is taken from IDLE, and also from DONE so results can be
  // produced back-to-back; start seen during RUN is simply dropped.
  always_comb begin
    accept = 1'b0;
    if (ena && start && (state == IDLE || state == DONE)) begin
      accept = 1'b1;
    end
  end

  // Sum bits enter from the MSB side, so after WIDTH shifts bit 0 of the
  // result has reached sum[0]. The final carry lands in sum[WIDTH].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        state   <= RUN;
        bit_cnt <= '0;
        a_sr    <= a;
        b_sr    <= b;
        carry   <= 1'b0;
        sum     <= '0;
        busy    <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
          end
          RUN: begin
            a_sr            <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr            <= {1'b0, b_sr[WIDTH-1:1]};
            carry           <= fa_cout;
            sum[WIDTH-1:0]  <= {fa_s, sum[WIDTH-1:1]};
            bit_cnt         <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              sum[WIDTH] <= fa_cout;
              bit_cnt    <= '0;
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            done  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl (WIDTH = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;

  int tests_run;
  int tests_failed;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] new_a,
                               input logic [WIDTH-1:0] new_b,
                               input logic new_start,
                               input logic new_ena);
    a     = new_a;
    b     = new_b;
    start = new_start;
    ena   = new_ena;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge. Unless already_started, raises start with the
  // operands so the next rising edge accepts them. Cycle n counts falling
  // edges after the acceptance edge; the loop stops on the first done.
  task automatic runOp(input string tag,
                       input logic [WIDTH-1:0] op_a,
                       input logic [WIDTH-1:0] op_b,
                       input bit already_started,
                       input int stall_at,
                       input bit hold_start,
                       input int pulse_at,
                       input logic [WIDTH-1:0] next_a,
                       input logic [WIDTH-1:0] next_b,
                       input logic [WIDTH:0] exp_sum,
                       input int exp_lat);
    int n;
    int busy_cnt;
    if (!already_started) begin
      applyStimulus(op_a, op_b, 1'b1, 1'b1);
    end
    n = 0;
    busy_cnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) busy_cnt++;
      if (n == 1) begin
        a = next_a;
        b = next_b;
        if (!hold_start) start = 1'b0;
      end
      if (pulse_at > 0 && n == pulse_at) start = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
      if (stall_at > 0 && n == stall_at) ena = 1'b0;
      if (stall_at > 0 && n == stall_at + 3) ena = 1'b1;
    end
    checkOutput({tag, " latency"}, n, exp_lat);
    checkOutput({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({tag, " sum"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int done_cnt;
    tests_run    = 0;
    tests_failed = 0;

    // Reset then idle
    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("in reset outputs", {29'd0, busy, done, 1'b0} | 32'(sum), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle outputs", {22'd0, busy, done, sum}, 32'd0);
    end

    // Basic add and carry-out cases
    runOp("basic", 8'h5A, 8'h3C, 0, 0, 0, 0, 8'h5A, 8'h3C, 9'h096, 9);
    @(negedge clk);
    checkOutput("basic done one cycle", 32'(done), 32'd0);
    checkOutput("basic sum held", 32'(sum), 32'h096);
    runOp("carry1", 8'hFF, 8'h01, 0, 0, 0, 0, 8'hFF, 8'h01, 9'h100, 9);
    @(negedge clk);
    runOp("carry2", 8'hFF, 8'hFF, 0, 0, 0, 0, 8'hFF, 8'hFF, 9'h1FE, 9);
    @(negedge clk);

    // Start pulsed during RUN must be ignored
    runOp("ignored", 8'h10, 8'h20, 0, 0, 0, 3, 8'h01, 8'h01, 9'h030, 9);
    @(negedge clk);
    checkOutput("ignored back to idle busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("ignored extra done pulses", done_cnt, 0);
    checkOutput("ignored sum held", 32'(sum), 32'h030);

    // ena stall mid-RUN, start held into DONE for back-to-back
    runOp("stall", 8'h12, 8'h34, 0, 3, 1, 0, 8'h01, 8'h02, 9'h046, 12);
    runOp("b2b", 8'h01, 8'h02, 1, 0, 0, 0, 8'h01, 8'h02, 9'h003, 9);
    @(negedge clk);
    checkOutput("b2b done one cycle", 32'(done), 32'd0);

    // Reset in the middle of an operation
    applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    checkOutput("async reset sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("no done after reset", done_cnt, 0);
    runOp("after reset", 8'h03, 8'h04, 0, 0, 0, 0, 8'h03, 8'h04, 9'h007, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a single 1-bit full-adder cell across the bits of two WIDTH-bit operands, one bit per enabled clock. It trades area for latency, reusing one half-adder-pair cell instead of a WIDTH-bit ripple adder. It sits behind the tile's I/O wrapper, which drives start and the operands and reads the result and status.

## Interface

Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  global enable; when low, all state holds.
- start  input  1  request a new addition; level-sampled.
- a  input  WIDTH  operand A; captured on start acceptance.
- b  input  WIDTH  operand B; captured on start acceptance.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse; the result is valid from this cycle.
- sum  output  WIDTH+1  result {carry_out, sum bits}; held until the next acceptance.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: if ena && start, then load a and b into shift registers, clear carry, set bit counter to 0, clear sum, and go to RUN. Otherwise hold.
- RUN: each ena cycle, the full-adder cell computes s = a_sr[0]^b_sr[0]^carry and the next carry.
  - s is shifted into sum from the MSB side; a_sr and b_sr shift right by one; the counter increments.
  - When the counter reaches WIDTH-1, that bit is the final bit: sum[WIDTH] takes the carry out, sum[WIDTH-1:0] holds the completed sum, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle.
  - If ena && start, the new operation is accepted (back-to-back, same loading as IDLE) and the FSM goes to RUN.
  - Otherwise the FSM goes to IDLE.
- start while in RUN is ignored; it is not queued.
- Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow can occur.
- a and b may change freely after acceptance; only the captured copies are used.
- ena low freezes the FSM, counter, shift registers, carry and outputs. done stays asserted if it was asserted, and lasts one ena-high cycle.

## Timing

- Reset values: busy=0, done=0, sum=0, FSM=IDLE, counter=0, carry=0.
- Acceptance edge is k (start sampled high in IDLE or DONE).
  - busy=1 from edge k through edge k+WIDTH.
  - done=1 for the cycle following edge k+WIDTH.
  - Latency is WIDTH+1 clocks from acceptance to done, with ena continuously high.
- A WIDTH=8 operation occupies 9 cycles. Back-to-back throughput is one result per WIDTH+1 cycles.
- Each ena-low cycle extends the latency by one.
- rst_n low at any time, including mid-RUN, asynchronously forces the reset values. The in-flight operation is discarded with no done pulse.
- The first acceptance is possible on the first rising edge after rst_n deasserts.

## Structure

- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - DEFAULT_WIDTH = 8;
  - the counter width function clog2(WIDTH).
- Sub-module bit_full_adder: combinational (a, b, cin) → (s, cout), built from two half-adder stages plus an OR. It is the only arithmetic in the block.
- The controller holds the FSM, counter, operand shift registers, carry flop and sum register.

## Test plan

- Reset then idle: rst_n low for 2 cycles, then high, with start=0. busy=0, done=0 and sum=0 remain for 20 cycles.
- Basic add: a=0x5A, b=0x3C, start held 1 cycle. done pulses exactly 9 cycles after acceptance, sum=0x096, and busy=1 for the 8 preceding cycles.
- Carry-out: a=0xFF, b=0x01, giving sum=0x100. Then a=0xFF, b=0xFF, giving sum=0x1FE.
- Ignored start: accept a=0x10, b=0x20, and pulse start with a=0x01, b=0x01 during RUN. The result is 0x030, only one done pulse occurs, and the FSM returns to IDLE.
- ena stall and back-to-back: drop ena for 3 cycles mid-RUN, so done arrives at 12 cycles. Hold start high through DONE with a=0x01, b=0x02: the next acceptance happens in the DONE cycle and gives sum=0x003 nine cycles later.
- Reset mid-operation: assert rst_n low at cycle 4 of RUN. busy, done and sum go to 0 immediately (asynchronously), and no done pulse follows. A fresh add of 0x03+0x04 then gives 0x007.
